pwm_encoder: RTL
================

# pwm_encoder

Converts an 8-bit duty value into a pulse-width-modulated output. It is the consumer end of the team's duty-ramp generator: it accepts that block's 8-bit duty word and drives the LED/motor pin. The block runs a free-running 255-cycle PWM period on `clk_div`. Duty updates are double-buffered so a new value only takes effect at a period boundary, which keeps the output glitch-free.

## Interface
- `WIDTH`, 8, duty/counter width; period = 2^WIDTH−1 cycles (255)
- `clk_div`  in  1  block clock, rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `en`  in  1  level; 1 = generate PWM, 0 = finish current period, then idle
- `duty_in`  in  WIDTH  requested duty, sampled only when `duty_load`=1
- `duty_load`  in  1  single-cycle strobe; captures `duty_in` into shadow register
- `duty_ack`  out  1  one-cycle pulse, cycle after `duty_load` accepted
- `pwm_out`  out  1  registered PWM output
- `period_start`  out  1  one-cycle pulse in each cycle where counter = 0 (RUN/STOP)
- `busy`  out  1  1 in RUN or STOP
- `active_duty`  out  WIDTH  duty currently applied

## Operation
- States:
  - IDLE: counter held at 0, `pwm_out`=0.
  - RUN: counter counts 0..254, wraps to 0.
  - STOP: as RUN; on the last count (254), goes to IDLE instead of wrapping.
- State transitions:
  - IDLE→RUN when `en`=1. On this edge: counter=0, `active_duty` ← shadow.
  - RUN→STOP when `en`=0.
  - STOP→RUN when `en`=1 before count 254. No interruption; counter continues.
  - STOP→IDLE at counter 254 with `en`=0.
- Shadow register:
  - Written on every accepted `duty_load`, in any state.
  - A back-to-back load overwrites the shadow; the last value wins.
  - `duty_ack` pulses once per load.
- Transfer: `active_duty` ← shadow on the counter 254→0 wrap in RUN, and on IDLE→RUN entry.
  - `duty_load` in the same cycle as a transfer: the transfer uses the old shadow; the new value applies from the following period.
- Compare:
  - `pwm_out` next = (counter < `active_duty`), unsigned, WIDTH bits.
  - Duty 0 gives a constant 0. Duty 255 gives a constant 1; no low cycle, because counter max = 254.
  - High time per period = `active_duty` cycles exactly.
- Reset (async, any state, including mid-period):
  - State=IDLE, counter=0, shadow=0, `active_duty`=0.
  - `pwm_out`=0, `duty_ack`=0, `period_start`=0, `busy`=0.

## Timing
- All outputs are registered.
- `pwm_out` lags the counter by one cycle: the value driven in cycle t reflects the counter in cycle t−1.
- First PWM edge after `en` rises (IDLE): `busy`=1 after 1 edge; `pwm_out` reflects counter 0 after 2 edges.
- `duty_ack`: exactly 1 cycle after the `duty_load` edge.
- `period_start`: asserted in the same cycle the counter register holds 0.
  - The first assertion is 1 edge after IDLE→RUN.
  - It then repeats every 255 cycles.
- After `en`=0 in RUN, `busy` falls 1 cycle after counter 254 is reached; `pwm_out`=0 from the following cycle.
- Duty change latency: from shadow write to effect is ≤ 255 cycles (the next wrap).

## Structure
- Shared package `pwm_pkg`:
  - State enum {IDLE, RUN, STOP}.
  - `PWM_WIDTH`=8.
  - `PWM_LAST`=2^WIDTH−2 (254).
  - Shared with the ramp generator's duty type.
- One sub-module, `pwm_period_counter`: counter with `clr`, `inc`, and `wrap` (= count at `PWM_LAST`) outputs.
- FSM, shadow/active registers and compare stay in the top level.

## Test plan
- Reset with `en`=1 held, then release: `pwm_out`=0, `busy`=0 during reset; `period_start` first asserts 1 edge after release, then every 255 cycles.
- Load 64, `en`=1: `duty_ack` asserts 1 cycle after the load; every period `pwm_out` is high exactly 64 cycles, then low 191.
- Boundary duties: load 0 → `pwm_out` stays 0 for 3 periods. Load 255 → stays 1 for 3 periods. Load 1 → exactly 1 high cycle per period.
- Mid-period update: running at 100, load 200 at counter 50 → the current period keeps 100 high cycles; the next period has 200; `active_duty` changes at the wrap.
- Collision: `duty_load`=30 in the cycle with counter=254 while the shadow holds 80 → the next period uses 80; the period after uses 30.
- `en`=0 at counter 10, re-asserted at counter 100 → no gap, `busy` stays 1. `en`=0 again with no re-assert → the period completes to 254, then `busy`=0 and `pwm_out`=0. Async `rst` mid-high-phase → `pwm_out`=0 immediately.

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared PWM definitions: FSM states, duty word type and period constants.
// The duty ramp generator uses the same duty type so both ends agree on the width.
package pwm_pkg;

  localparam int PWM_WIDTH = 8;
  localparam logic [PWM_WIDTH-1:0] PWM_LAST = 8'd254;

  typedef logic [PWM_WIDTH-1:0] pwm_duty_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } pwm_state_e;

endpackage

// File: rtl/pwm_encoder_if.sv
// Duty handshake and PWM status bundle between a duty source (master) and
// the PWM encoder (slave).
interface pwm_encoder_if #(
  parameter int WIDTH = 8
);
  logic             en;
  logic [WIDTH-1:0] duty_in;
  logic             duty_load;
  logic             duty_ack;
  logic             pwm_out;
  logic             period_start;
  logic             busy;
  logic [WIDTH-1:0] active_duty;

  modport master (
    output en, duty_in, duty_load,
    input  duty_ack, pwm_out, period_start, busy, active_duty
  );

  modport slave (
    input  en, duty_in, duty_load,
    output duty_ack, pwm_out, period_start, busy, active_duty
  );
endinterface

// File: rtl/pwm_period_counter.sv
// PWM period counter: counts 0..LAST and wraps, with synchronous clear.
// wrap_o flags the last count of the period.
module pwm_period_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk_div,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] count_o,
  output logic             wrap_o
);

  localparam logic [WIDTH-1:0] LAST = {{(WIDTH-1){1'b1}}, 1'b0};
  localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  assign wrap_o  = (count_q == LAST);
  assign count_o = count_q;

  // Next count: clear wins over increment; the last count folds back to zero.
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = ZERO;
    end else if (inc_i) begin
      count_d = wrap_o ? ZERO : (count_q + ONE);
    end else begin
      count_d = count_q;
    end
  end

  // Count register.
  always_ff @(posedge clk_div or posedge rst) begin
    if (rst) begin
      count_q <= ZERO;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/pwm_encoder.sv
// PWM encoder: double-buffered duty (shadow -> active at period boundary),
// IDLE/RUN/STOP control and registered compare output.
module pwm_encoder
  import pwm_pkg::*;
#(
  parameter int WIDTH = PWM_WIDTH
) (
  input logic          clk_div,
  input logic          rst,
  pwm_encoder_if.slave bus
);

  localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};

  pwm_state_e       state_q, state_d;
  logic [WIDTH-1:0] cnt_s;
  logic             wrap_s;
  logic             clr_s;
  logic             inc_s;
  logic             xfer_s;
  logic [WIDTH-1:0] shadow_q, shadow_d;
  logic [WIDTH-1:0] active_q, active_d;
  logic             pwm_q, pwm_d;
  logic             ack_q, ack_d;
  logic             start_q, start_d;
  logic             busy_q, busy_d;

  pwm_period_counter #(.WIDTH(WIDTH)) u_counter (
    .clk_div (clk_div),
    .rst     (rst),
    .clr_i   (clr_s),
    .inc_i   (inc_s),
    .count_o (cnt_s),
    .wrap_o  (wrap_s)
  );

  // Control FSM plus next values of every registered output.
  always_comb begin
    state_d  = state_q;
    clr_s    = 1'b0;
    inc_s    = 1'b0;
    xfer_s   = 1'b0;
    case (state_q)
      IDLE: begin
        clr_s = 1'b1;
        if (bus.en) begin
          state_d = RUN;
          xfer_s  = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        inc_s = 1'b1;
        if (wrap_s && bus.en) begin
          xfer_s = 1'b1;
        end else if (wrap_s) begin
          // Disabled exactly on the last count: the period is already complete.
          state_d = IDLE;
          clr_s   = 1'b1;
        end else if (!bus.en) begin
          state_d = STOP;
        end else begin
          state_d = RUN;
        end
      end
      STOP: begin
        inc_s = 1'b1;
        if (bus.en) begin
          state_d = RUN;
          xfer_s  = wrap_s;
        end else if (wrap_s) begin
          state_d = IDLE;
          clr_s   = 1'b1;
        end else begin
          state_d = STOP;
        end
      end
      default: begin
        state_d = IDLE;
        clr_s   = 1'b1;
      end
    endcase

    // A load coinciding with a transfer lands in the shadow after the old value moved.
    shadow_d = bus.duty_load ? bus.duty_in : shadow_q;
    active_d = xfer_s ? shadow_q : active_q;
    ack_d    = bus.duty_load;
    pwm_d    = (state_q != IDLE) && (cnt_s < active_q);
    busy_d   = (state_d != IDLE);
    if (state_d == IDLE) begin
      start_d = 1'b0;
    end else begin
      start_d = clr_s || (inc_s && wrap_s) || (!inc_s && (cnt_s == ZERO));
    end
  end

  // State, duty buffers and registered outputs.
  always_ff @(posedge clk_div or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      shadow_q <= ZERO;
      active_q <= ZERO;
      pwm_q    <= 1'b0;
      ack_q    <= 1'b0;
      start_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      active_q <= active_d;
      pwm_q    <= pwm_d;
      ack_q    <= ack_d;
      start_q  <= start_d;
      busy_q   <= busy_d;
    end
  end

  assign bus.pwm_out      = pwm_q;
  assign bus.duty_ack     = ack_q;
  assign bus.period_start = start_q;
  assign bus.busy         = busy_q;
  assign bus.active_duty  = active_q;

endmodule
